eth_mac_cfg_regs: RTL

- AXI-Lite slave register bank on the MAC side of the Ethernet configuration path.
- Consumes the unicast-address writes issued by the upstream Ethernet configuration master at BASE_ADDR+0x700/0x704.
- Commits the 48-bit station address atomically to the MAC receive filter and pulses an update strobe.
- Provides read-back and a commit counter for software and verification.

---
 rtl/eth_cfg_pkg.sv | 40 ++++
 rtl/axil_hold_reg.sv | 37 +++
 rtl/eth_mac_cfg_regs.sv | 139 +++++++++++++
 3 files changed

// File: rtl/eth_cfg_pkg.sv
// Shared constants and helpers for the MAC-side Ethernet configuration registers.
// Holds the register offsets, AXI response codes and the address decode.
package eth_cfg_pkg;

    localparam logic [11:0] UWA0_OFF = 12'h700;
    localparam logic [11:0] UWA1_OFF = 12'h704;
    localparam logic [11:0] UCNT_OFF = 12'h708;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [47:0] DEFAULT_MAC = 48'h00_0A_35_00_00_00;

    typedef enum logic [1:0] {
        REG_UWA0,
        REG_UWA1,
        REG_UCNT,
        REG_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode(input logic [31:0] base, input logic [31:0] addr);
        if (addr[1:0] != 2'b00)                return REG_NONE;
        if (addr == base + {20'h0, UWA0_OFF}) return REG_UWA0;
        if (addr == base + {20'h0, UWA1_OFF}) return REG_UWA1;
        if (addr == base + {20'h0, UCNT_OFF}) return REG_UCNT;
        return REG_NONE;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/axil_hold_reg.sv
// One-deep valid/ready holding register with a full flag.
// ready is registered and mirrors ~full; pop empties the slot.
module axil_hold_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    input  logic             pop,
    output logic             full,
    output logic [WIDTH-1:0] held
);

    logic take;
    assign take = valid & ready;

    // take and pop are exclusive: take needs ~full, pop is only issued while full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full  <= 1'b0;
            ready <= 1'b0;
            held  <= '0;
        end else if (take) begin
            held  <= data;
            full  <= 1'b1;
            ready <= 1'b0;
        end else if (pop) begin
            full  <= 1'b0;
            ready <= 1'b1;
        end else begin
            ready <= ~full;
        end
    end

endmodule

// File: rtl/eth_mac_cfg_regs.sv
// AXI-Lite register bank holding the unicast station address for the MAC filter.
// A UWA1 write commits {UWA1, UWA0} atomically and pulses addr_update.
module eth_mac_cfg_regs
    import eth_cfg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h40C0_0000,
    parameter logic [47:0] RESET_MAC = DEFAULT_MAC
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    output logic [47:0] unicast_addr,
    output logic        addr_update,
    output logic        addr_valid
);

    logic        aw_full, w_full, exec;
    logic [31:0] aw_addr;
    logic [35:0] w_held;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic [31:0] uwa0;
    logic [15:0] uwa1, uwa1_new;
    logic [7:0]  ucnt;
    reg_sel_e    wsel, rsel;
    logic [31:0] rd_mux;
    logic [1:0]  rd_resp;

    assign exec = aw_full & w_full & ~S_AXI_BVALID;

    axil_hold_reg #(.WIDTH(32)) u_aw_hold (
        .clk   (aclk),
        .rst   (areset),
        .data  (S_AXI_AWADDR),
        .valid (S_AXI_AWVALID),
        .ready (S_AXI_AWREADY),
        .pop   (exec),
        .full  (aw_full),
        .held  (aw_addr)
    );

    axil_hold_reg #(.WIDTH(36)) u_w_hold (
        .clk   (aclk),
        .rst   (areset),
        .data  ({S_AXI_WSTRB, S_AXI_WDATA}),
        .valid (S_AXI_WVALID),
        .ready (S_AXI_WREADY),
        .pop   (exec),
        .full  (w_full),
        .held  (w_held)
    );

    assign w_data   = w_held[31:0];
    assign w_strb   = w_held[35:32];
    assign wsel     = decode(BASE_ADDR, aw_addr);
    assign uwa1_new = {w_strb[1] ? w_data[15:8] : uwa1[15:8],
                       w_strb[0] ? w_data[7:0]  : uwa1[7:0]};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            uwa0         <= RESET_MAC[31:0];
            uwa1         <= RESET_MAC[47:32];
            ucnt         <= '0;
            unicast_addr <= RESET_MAC;
            addr_update  <= 1'b0;
            addr_valid   <= 1'b0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= '0;
        end else begin
            addr_update <= 1'b0;
            if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
            if (exec) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= RESP_OKAY;
                case (wsel)
                    REG_UWA0: uwa0 <= merge_bytes(uwa0, w_data, w_strb);
                    REG_UWA1: begin
                        uwa1         <= uwa1_new;
                        unicast_addr <= {uwa1_new, uwa0};
                        ucnt         <= ucnt + 8'd1;
                        addr_update  <= 1'b1;
                        addr_valid   <= 1'b1;
                    end
                    default:  S_AXI_BRESP <= RESP_SLVERR;
                endcase
            end
        end
    end

    assign rsel = decode(BASE_ADDR, S_AXI_ARADDR);

    always_comb begin
        rd_mux  = '0;
        rd_resp = RESP_OKAY;
        case (rsel)
            REG_UWA0: rd_mux = uwa0;
            REG_UWA1: rd_mux = {16'h0, uwa1};
            REG_UCNT: rd_mux = {24'h0, ucnt};
            default:  rd_resp = RESP_SLVERR;
        endcase
    end

    // Read data is sampled from the registers before the same edge's write lands
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= '0;
        end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            S_AXI_RVALID  <= 1'b1;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RDATA   <= rd_mux;
            S_AXI_RRESP   <= rd_resp;
        end else if (S_AXI_RVALID && S_AXI_RREADY) begin
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
        end else begin
            S_AXI_ARREADY <= ~S_AXI_RVALID;
        end
    end

endmodule
